// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV64M multiply/divide unit with controller stall/flush handling
// Optional: define MULDIV_FAST_MUL_EN for a single-cycle multiplier on the MUL* path.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      ctrl_signal_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] result_o,
  output logic            muldiv_ready_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] CTRL_DEFAULT = 2'd0;
  localparam logic [1:0] CTRL_BLOCK   = 2'd1;
  localparam logic [1:0] CTRL_BUBBLE  = 2'd2;
  localparam logic [1:0] CTRL_BRANCH  = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic              word_q;
  logic [XLEN-1:0]   a_q;      // multiplicand (mul) or divisor (div), magnitude
  logic [XLEN-1:0]   sh_q;     // multiplier bits scanned MSB-first, or dividend -> quotient
  logic [XLEN-1:0]   rem_q;
  logic [2*XLEN-1:0] prod_q;
  logic              neg_q;    // negate product / quotient in FIX
  logic              neg_r;    // negate remainder in FIX
  logic [CW-1:0]     cnt_q;

  // Operand preparation at accept
  logic            is_div, sgn_a, sgn_b, neg_a, neg_b, b_zero, ovf, abort;
  logic [XLEN-1:0] ext_a, ext_b, abs_a, abs_b, sh_src, sh_init;

  always_comb begin
    is_div = op_i[2];
    sgn_a  = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    sgn_b  = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    ext_a  = rs1_i;
    ext_b  = rs2_i;
    if (word_i) begin
      ext_a = {{(XLEN-32){sgn_a & rs1_i[31]}}, rs1_i[31:0]};
      ext_b = {{(XLEN-32){sgn_b & rs2_i[31]}}, rs2_i[31:0]};
    end
    neg_a   = sgn_a & ext_a[XLEN-1];
    neg_b   = sgn_b & ext_b[XLEN-1];
    abs_a   = neg_a ? -ext_a : ext_a;
    abs_b   = neg_b ? -ext_b : ext_b;
    sh_src  = is_div ? abs_a : abs_b;
    sh_init = word_i ? {sh_src[31:0], {(XLEN-32){1'b0}}} : sh_src;
    b_zero  = word_i ? (rs2_i[31:0] == 32'd0) : (rs2_i == '0);
    ovf     = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
              (word_i ? (rs1_i[31:0] == 32'h8000_0000 && rs2_i[31:0] == 32'hFFFF_FFFF)
                      : (rs1_i == XMIN && rs2_i == '1));
    abort   = (ctrl_signal_i == CTRL_BUBBLE) || (ctrl_signal_i == CTRL_BRANCH);
  end

  // One radix-2 step for each datapath
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh, diff;
  logic              ge;
  logic [XLEN-1:0]   rem_next;

  always_comb begin
    mul_next = {prod_q[2*XLEN-2:0], 1'b0} + (sh_q[XLEN-1] ? {{XLEN{1'b0}}, a_q} : '0);
    rem_sh   = {rem_q, sh_q[XLEN-1]};
    diff     = rem_sh - {1'b0, a_q};
    ge       = ~diff[XLEN];
    rem_next = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  end

  // Sign fix-up and half/word selection
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, raw, fix_val;

  always_comb begin
    prod_s = neg_q ? -prod_q : prod_q;
    quot_s = neg_q ? -sh_q : sh_q;
    rem_s  = neg_r ? -rem_q : rem_q;
    case (op_q)
      OP_MUL:                        raw = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  raw = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               raw = quot_s;
      default:                       raw = rem_s;
    endcase
    fix_val = word_q ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      result_o       <= '0;
      muldiv_ready_o <= 1'b0;
      busy_o         <= 1'b0;
      cnt_q          <= '0;
      op_q           <= '0;
      word_q         <= 1'b0;
      a_q            <= '0;
      sh_q           <= '0;
      rem_q          <= '0;
      prod_q         <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
    end else if (ctrl_signal_i == CTRL_BLOCK) begin
      state <= state;
    end else if (abort) begin
      state          <= S_IDLE;
      muldiv_ready_o <= 1'b0;
      busy_o         <= 1'b0;
    end else if (ctrl_signal_i == CTRL_DEFAULT) begin
      case (state)
        S_IDLE: begin
          muldiv_ready_o <= 1'b0;
          if (start_i) begin
            op_q   <= op_i;
            word_q <= word_i;
            a_q    <= is_div ? abs_b : abs_a;
            sh_q   <= sh_init;
            rem_q  <= '0;
            prod_q <= '0;
            neg_q  <= neg_a ^ neg_b;
            neg_r  <= is_div & neg_a;
            cnt_q  <= word_i ? CW'(32) : CW'(XLEN);
            busy_o <= 1'b1;
            state  <= S_CALC;
            if (is_div && b_zero) begin
              // Architected x/0 results: quotient all ones, remainder is the raw dividend
              sh_q  <= '1;
              rem_q <= rs1_i;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_FIX;
            end else if (is_div && ovf) begin
              sh_q  <= rs1_i;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_FIX;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              prod_q <= fast_prod;
              state  <= S_FIX;
            end
`endif
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q - CW'(1);
          if (op_q[2]) begin
            rem_q <= rem_next;
            sh_q  <= {sh_q[XLEN-2:0], ge};
          end else begin
            prod_q <= mul_next;
            sh_q   <= {sh_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          result_o       <= fix_val;
          muldiv_ready_o <= 1'b1;
          busy_o         <= 1'b0;
          state          <= S_DONE;
        end
        default: begin
          muldiv_ready_o <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (directed vectors, stall/flush/reset cases)
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ctrl = 2'd0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        word = 1'b0;
  logic [63:0] rs1 = '0;
  logic [63:0] rs2 = '0;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  muldiv_unit #(.XLEN(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .ctrl_signal_i  (ctrl),
    .start_i        (start),
    .op_i           (op),
    .word_i         (word),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .result_o       (result),
    .muldiv_ready_o (ready),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML  = 2;
  localparam int MLW = 2;
`else
  localparam int ML  = 66;
  localparam int MLW = 34;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          due;
    string       name;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int c0 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expectation, including its cycle
  always @(negedge clk) begin
    if (rst && ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_ready", 64'(ready), 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input bit push, input string name);
    @(negedge clk);
    op = o; word = w; rs1 = a; rs2 = b; start = 1'b1;
    c0 = cyc;
    if (push) sbq.push_back('{exp, c0 + lat, name});
    @(negedge clk);
    start = 1'b0;
    rs1 = {$urandom, $urandom};
    rs2 = {$urandom, $urandom};
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ready within %0d cycles, want ready", name, n);
      sbq.delete();
    end
  endtask

  typedef struct {
    logic [2:0]  o;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, ML, "mul"});
    vecs.push_back('{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2, "div_ovf"});
    vecs.push_back('{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 2, "rem_ovf"});
    vecs.push_back('{3'd5, 1'b0, 64'd100, 64'd0, '1, 2, "divu_zero"});
    vecs.push_back('{3'd7, 1'b1, 64'h1_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 2, "remuw_zero"});
    vecs.push_back('{3'd1, 1'b0, '1, '1, 64'd0, ML, "mulh_m1"});
    vecs.push_back('{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, '1, ML, "mulh_min"});
    vecs.push_back('{3'd2, 1'b0, '1, 64'd2, '1, ML, "mulhsu"});
    vecs.push_back('{3'd0, 1'b1, 64'h1_0000_0003, 64'h7FFF_FFFF, 64'h0000_0000_7FFF_FFFD, MLW, "mulw"});
    vecs.push_back('{3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, "div_neg"});
    vecs.push_back('{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66, "remu"});
    vecs.push_back('{3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, '1, 34, "divuw"});
    vecs.push_back('{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2, "divw_ovf"});
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1, vecs[i].name);
      wait_done(vecs[i].name);
    end

    // REM with a 10-cycle controller Block in the middle of CALC
    issue(3'd6, 1'b0, -64'sd7, 64'd2, '1, 76, 1'b1, "rem_block");
    while (cyc < c0 + 10) @(negedge clk);
    ctrl = 2'd1;
    while (cyc < c0 + 15) @(negedge clk);
    check("block_busy", 64'(busy), 64'd1);
    check("block_ready", 64'(ready), 64'd0);
    while (cyc < c0 + 20) @(negedge clk);
    ctrl = 2'd0;
    wait_done("rem_block");

    issue(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1'b1, "divw");
    wait_done("divw");

    // Branch flush at cycle 5 of a DIVW: no ready, result held
    issue(3'd4, 1'b1, 64'd100, 64'd3, 64'd0, 0, 1'b0, "divw_flush");
    while (cyc < c0 + 5) @(negedge clk);
    ctrl = 2'd3;
    @(negedge clk);
    ctrl = 2'd0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_ready", 64'(ready), 64'd0);
    check("flush_result", result, 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (40) @(negedge clk);

    // Abort wins over start in the same cycle
    @(negedge clk);
    op = 3'd4; word = 1'b0; rs1 = 64'd9; rs2 = 64'd3; start = 1'b1; ctrl = 2'd2;
    @(negedge clk);
    start = 1'b0; ctrl = 2'd0;
    check("abort_prio_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    check("abort_prio_result", result, 64'hFFFF_FFFF_FFFF_FFFD);

    // Reset in the middle of a DIV, then a fresh MULHU
    issue(3'd4, 1'b0, 64'd100, 64'd7, 64'd0, 0, 1'b0, "div_reset");
    while (cyc < c0 + 20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_result", result, 64'd0);
    check("midreset_ready", 64'(ready), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    issue(3'd3, 1'b0, '1, 64'd2, 64'd1, ML, 1'b1, "mulhu");
    wait_done("mulhu");
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
